// File: rtl/musa_if_pkg.sv
// Shared types and constants for the MUSA IF-stage PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package musa_if_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [PC_W-1:0] TRAP_VECTOR_DEF  = 32'h0000_0010;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        HALTED   = 2'd2,
        FAULT    = 2'd3
    } seq_state_t;

    // Sequential successor; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] cur);
        return cur + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: fault > halt > ret > call > jump/branch > sequential.
// Latency: purely combinational.
// Backpressure: stall holds pc/state and suppresses both stack strobes.
//
// Ports: state/requests/fault_edge in, current pc, target and popped stack
// value in; next pc, next state, next trap flag and push/pop strobes out.
// Optional build macro: PC_SEQ_TRAP_EN (fault vectors to TRAP_VECTOR
// instead of parking in FAULT).
module pc_next_sel
    import musa_if_pkg::*;
#(
    parameter logic [PC_W-1:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
    input  seq_state_t      state,
    input  logic            stall,
    input  logic            halt,
    input  logic            jump,
    input  logic            branch,
    input  logic            call,
    input  logic            ret,
    input  logic            fault_edge,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] stack_out,
    output logic [PC_W-1:0] pc_nxt,
    output seq_state_t      state_nxt,
    output logic            trap_nxt,
    output logic            push,
    output logic            pop
);

    logic [PC_W-1:0] fault_pc;
    seq_state_t      fault_state;
    logic            fault_trap;

`ifdef PC_SEQ_TRAP_EN
    assign fault_pc    = TRAP_VECTOR;
    assign fault_state = RUN;
    assign fault_trap  = 1'b1;
`else
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
    assign fault_pc    = pc;
    assign fault_state = FAULT;
    assign fault_trap  = 1'b0;
`endif

    always_comb begin
        pc_nxt    = pc;
        state_nxt = state;
        trap_nxt  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            RUN: begin
                // The fault edge lasts one cycle only, so it is honoured
                // even while stalled rather than being lost.
                if (fault_edge) begin
                    pc_nxt    = fault_pc;
                    state_nxt = fault_state;
                    trap_nxt  = fault_trap;
                end else if (!stall) begin
                    if (halt) begin
                        state_nxt = HALTED;
                    end else if (ret) begin
                        pop       = 1'b1;
                        state_nxt = RET_WAIT;
                    end else if (call) begin
                        push   = 1'b1;
                        pc_nxt = target;
                    end else if (jump || branch) begin
                        pc_nxt = target;
                    end else begin
                        pc_nxt = pc_inc(pc);
                    end
                end
            end
            RET_WAIT: begin
                // A pop from an empty stack shows up here as the fault edge.
                if (fault_edge) begin
                    pc_nxt    = fault_pc;
                    state_nxt = fault_state;
                    trap_nxt  = fault_trap;
                end else if (!stall) begin
                    pc_nxt    = stack_out;
                    state_nxt = RUN;
                end
            end
            default: ;  // HALTED and FAULT are left only through reset
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the IF stage, driving the return-address stack.
// Latency: redirect 1 cycle, return 2 cycles (pop edge, load edge).
// Backpressure: stall holds pc/state; strobes drop to 0 and requests are lost.
//
// Ports: clock, reset (async active-low); stall/halt/jump/branch/call/ret and
// target from upstream; stackOut/stackOverflow from Stack; pc, stackData,
// writeStack, readStack, busy, halted, trap out.
// Optional build macro: PC_SEQ_TRAP_EN (stack fault vectors to TRAP_VECTOR
// with a one-cycle trap pulse; otherwise the core freezes in FAULT).
module pc_sequencer
    import musa_if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        jump,
    input  logic        branch,
    input  logic        call,
    input  logic        ret,
    input  logic [31:0] target,
    input  logic [31:0] stackOut,
    input  logic        stackOverflow,
    output logic [31:0] pc,
    output logic [31:0] stackData,
    output logic        writeStack,
    output logic        readStack,
    output logic        busy,
    output logic        halted,
    output logic        trap
);

    seq_state_t      state_q;
    seq_state_t      state_nxt;
    logic            ovf_q;
    logic            fault_edge;
    logic [PC_W-1:0] pc_nxt;
    logic            trap_nxt;
    logic            push_sel;
    logic            pop_sel;

    // Stack's flag is sticky, so only its rising edge counts as a new fault.
    assign fault_edge = stackOverflow & ~ovf_q;

    pc_next_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .state      (state_q),
        .stall      (stall),
        .halt       (halt),
        .jump       (jump),
        .branch     (branch),
        .call       (call),
        .ret        (ret),
        .fault_edge (fault_edge),
        .pc         (pc),
        .target     (target),
        .stack_out  (stackOut),
        .pc_nxt     (pc_nxt),
        .state_nxt  (state_nxt),
        .trap_nxt   (trap_nxt),
        .push       (push_sel),
        .pop        (pop_sel)
    );

    assign stackData  = pc_inc(pc);
    // Keep Stack untouched while the core is held in reset.
    assign writeStack = push_sel & reset;
    assign readStack  = pop_sel & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_VECTOR;
            state_q <= RUN;
            busy    <= 1'b0;
            halted  <= 1'b0;
            trap    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            state_q <= state_nxt;
            busy    <= (state_nxt == RET_WAIT);
            halted  <= (state_nxt == HALTED) || (state_nxt == FAULT);
            trap    <= trap_nxt;
            ovf_q   <= stackOverflow;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: 8-entry stack model, directed scenarios, then random
// traffic. A reference model predicts every cycle's outputs into a queue; a
// separate monitor pops and compares them mid-cycle.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0010;

    logic        clock;
    logic        reset;
    logic        stall, halt, jump, branch, call, ret;
    logic [31:0] target;
    logic [31:0] stackOut;
    logic        stackOverflow;
    logic [31:0] pc, stackData;
    logic        writeStack, readStack, busy, halted, trap;

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .halt          (halt),
        .jump          (jump),
        .branch        (branch),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .stackOut      (stackOut),
        .stackOverflow (stackOverflow),
        .pc            (pc),
        .stackData     (stackData),
        .writeStack    (writeStack),
        .readStack     (readStack),
        .busy          (busy),
        .halted        (halted),
        .trap          (trap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- Stack (8 entries, sticky fault flag) ----------------
    logic [31:0] stk_mem [8];
    int          stk_depth;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            stk_depth     <= 0;
            stackOverflow <= 1'b0;
            stackOut      <= 32'h0;
        end else if (writeStack) begin
            if (stk_depth == 8) stackOverflow <= 1'b1;
            else begin
                stk_mem[stk_depth] <= stackData;
                stk_depth          <= stk_depth + 1;
            end
        end else if (readStack) begin
            if (stk_depth == 0) stackOverflow <= 1'b1;
            else begin
                stackOut  <= stk_mem[stk_depth-1];
                stk_depth <= stk_depth - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] sdata;
        logic        busy, halted, trap, wr, rd;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model: architectural view of the core plus its return list.
    int          m_mode;     // 0 running, 1 awaiting popped address, 2 halted, 3 frozen
    logic [31:0] m_pc;
    logic [31:0] m_ret_val;
    logic [31:0] m_ras[$];
    bit          m_sticky, m_pend, m_trap;

    task automatic model_step(input bit rst, input bit st, input bit hl, input bit jp,
                              input bit br, input bit cl, input bit rt, input logic [31:0] tgt);
        exp_t e;
        bit   n_trap;
        if (rst) begin
            m_mode = 0; m_pc = RV; m_ret_val = 32'h0; m_ras.delete();
            m_sticky = 0; m_pend = 0; m_trap = 0;
        end
        e.pc = m_pc; e.sdata = m_pc + 32'd1; e.busy = (m_mode == 1);
        e.halted = (m_mode >= 2); e.trap = m_trap; e.wr = 0; e.rd = 0;
        n_trap = 0;
        if (!rst) begin
            if (m_pend) begin
                m_pend = 0;
`ifdef PC_SEQ_TRAP_EN
                m_pc = TV; m_mode = 0; n_trap = 1;
`else
                m_mode = 3;
`endif
            end else if (m_mode == 0 && !st) begin
                if (hl) m_mode = 2;
                else if (rt) begin
                    e.rd = 1; m_mode = 1;
                    if (m_ras.size() == 0) begin
                        if (!m_sticky) m_pend = 1;
                        m_sticky = 1;
                    end else m_ret_val = m_ras.pop_back();
                end else if (cl) begin
                    e.wr = 1;
                    if (m_ras.size() == 8) begin
                        if (!m_sticky) m_pend = 1;
                        m_sticky = 1;
                    end else m_ras.push_back(m_pc + 32'd1);
                    m_pc = tgt;
                end else if (jp || br) m_pc = tgt;
                else m_pc = m_pc + 32'd1;
            end else if (m_mode == 1 && !st) begin
                m_pc = m_ret_val; m_mode = 0;
            end
        end
        m_trap = n_trap;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cycle, act, req);
        end
    endtask

    exp_t mon_e;
    always @(negedge clock) begin
        cycle++;
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("pc",         pc,                 mon_e.pc);
            chk("stackData",  stackData,          mon_e.sdata);
            chk("writeStack", {31'b0, writeStack}, {31'b0, mon_e.wr});
            chk("readStack",  {31'b0, readStack},  {31'b0, mon_e.rd});
            chk("busy",       {31'b0, busy},       {31'b0, mon_e.busy});
            chk("halted",     {31'b0, halted},     {31'b0, mon_e.halted});
            chk("trap",       {31'b0, trap},       {31'b0, mon_e.trap});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit st, input bit hl, input bit jp, input bit br,
                       input bit cl, input bit rt, input logic [31:0] tgt);
        @(negedge clock);
        reset = 1'b1; stall = st; halt = hl; jump = jp; branch = br;
        call = cl; ret = rt; target = tgt;
        model_step(0, st, hl, jp, br, cl, rt, tgt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset = 1'b0; stall = 0; halt = 0; jump = 0; branch = 0;
            call = 0; ret = 0; target = 32'h0;
            model_step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b0; stall = 0; halt = 0; jump = 0; branch = 0;
        call = 0; ret = 0; target = 32'h0;
        do_reset(2);

        // sequential 0..5, call/return
        idle(5);
        cyc(0, 0, 0, 0, 1, 0, 32'h40);
        idle(2);
        cyc(0, 0, 0, 0, 0, 1, 32'h0);
        idle(3);

        // nine nested calls -> overflow fault
        do_reset(1);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1, 0, 32'h100 + i);
        idle(4);

        // return from empty stack -> underflow fault
        do_reset(1);
        cyc(0, 0, 0, 0, 0, 1, 32'h0);
        idle(4);

        // wrap, then all redirect requests together
        do_reset(1);
        cyc(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF);
        idle(2);
        cyc(0, 0, 1, 1, 1, 0, 32'h77);
        idle(1);

        // stalled RET_WAIT, then reset during RET_WAIT
        do_reset(1);
        cyc(0, 0, 0, 0, 1, 0, 32'h20);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);
        cyc(0, 0, 0, 0, 1, 0, 32'h30);
        cyc(0, 0, 0, 0, 0, 1, 32'h0);
        do_reset(1);
        idle(2);

        // halt
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        idle(3);
        do_reset(1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ((m_mode >= 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
                do_reset(1);
            else
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                    ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clock);
        #5;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
